// File: rtl/knight_pkg.sv
// Shared constants and types for the knight's tour command path.
// Opcodes and headings match the cmd_proc command format.
package knight_pkg;

  localparam logic [3:0] CAL_GYRO = 4'h2;
  localparam logic [3:0] MOVE     = 4'h4;
  localparam logic [3:0] MOVE_FF  = 4'h5;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] MV_ACK  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLD_V,
    HORZ,
    HOLD_H
  } tour_state_t;

endpackage

// File: rtl/knight_move_decode.sv
// Turns a one-hot knight move into its vertical and horizontal leg commands.
// Zero or multi-hot moves fall back to the b0 move (+1,+2).
module knight_move_decode
  import knight_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic [1:0] dx_mag, dy_mag;
  logic       dx_neg, dy_neg;

  always_comb begin
    dx_mag = 2'd1;
    dx_neg = 1'b0;
    dy_mag = 2'd2;
    dy_neg = 1'b0;
    case (move)
      8'h02: begin dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2; dy_neg = 1'b0; end
      8'h04: begin dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1; dy_neg = 1'b0; end
      8'h08: begin dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1; dy_neg = 1'b1; end
      8'h10: begin dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2; dy_neg = 1'b1; end
      8'h20: begin dx_mag = 2'd1; dx_neg = 1'b0; dy_mag = 2'd2; dy_neg = 1'b1; end
      8'h40: begin dx_mag = 2'd2; dx_neg = 1'b0; dy_mag = 2'd1; dy_neg = 1'b1; end
      8'h80: begin dx_mag = 2'd2; dx_neg = 1'b0; dy_mag = 2'd1; dy_neg = 1'b0; end
      default: ;
    endcase
  end

  assign vert_cmd = {MOVE,    (dy_neg ? SOUTH : NORTH), 2'b00, dy_mag};
  assign horz_cmd = {MOVE_FF, (dx_neg ? WEST  : EAST),  2'b00, dx_mag};

endmodule

// File: rtl/tour_cmd_seq.sv
// Arbitrates cmd_proc between the UART path and tour replay, splitting each
// knight move into a vertical leg then a horizontal leg with fanfare.
module tour_cmd_seq
  import knight_pkg::*;
#(
  parameter logic [4:0] LAST_MV = 5'd23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  tour_state_t state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [15:0] vert_cmd, horz_cmd;

  knight_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Index only advances below LAST_MV, so it saturates without wrapping.
  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = MV_ACK;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = POS_ACK;
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = 5'd0;
        end
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLD_V;
      end
      HOLD_V: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLD_H;
      end
      HOLD_H: begin
        cmd = horz_cmd;
        if (mv_indx_q == LAST_MV) resp = POS_ACK;
        if (send_resp) begin
          if (mv_indx_q == LAST_MV) begin
            state_d = IDLE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed self-checking bench for tour_cmd_seq: UART passthrough, leg
// sequencing, full tour, arbitration, stray events and mid-tour reset.
module tb_tour_cmd_seq;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int numAsserts = 0;
  int numFails   = 0;
  int legCount   = 0;

  tour_cmd_seq #(.LAST_MV(5'd23)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed leg commands for each knight move
  function automatic logic [15:0] expVert(input logic [7:0] mv);
    case (mv)
      8'h01: return 16'h4002;
      8'h02: return 16'h4002;
      8'h04: return 16'h4001;
      8'h08: return 16'h47F1;
      8'h10: return 16'h47F2;
      8'h20: return 16'h47F2;
      8'h40: return 16'h47F1;
      8'h80: return 16'h4001;
      default: return 16'h4002;
    endcase
  endfunction

  function automatic logic [15:0] expHorz(input logic [7:0] mv);
    case (mv)
      8'h01: return 16'h5BF1;
      8'h02: return 16'h53F1;
      8'h04: return 16'h53F2;
      8'h08: return 16'h53F2;
      8'h10: return 16'h53F1;
      8'h20: return 16'h5BF1;
      8'h40: return 16'h5BF2;
      8'h80: return 16'h5BF2;
      default: return 16'h5BF1;
    endcase
  endfunction

  // Move pattern for the tour, including a zero and a multi-hot move
  function automatic logic [7:0] tourMove(input int idx);
    logic [7:0] one;
    one = 8'h01;
    if (idx == 5)  return 8'h00;
    if (idx == 13) return 8'h03;
    return one << (idx % 8);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    numAsserts++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one-edge pulses, then drop them and let outputs settle
  task automatic applyStimulus(input logic st, input logic cr, input logic sr);
    start_tour  = st;
    clr_cmd_rdy = cr;
    send_resp   = sr;
    @(posedge clk);
    #2;
    start_tour  = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    #1;
  endtask

  task automatic runMove(input int idx, input logic [4:0] lastIdx);
    logic [7:0] mv;
    mv   = tourMove(idx);
    move = mv;
    #1;
    checkOutput($sformatf("mv_indx_%0d", idx), {11'b0, mv_indx}, idx[15:0]);
    checkOutput($sformatf("vert_cmd_%0d", idx), cmd, expVert(mv));
    checkOutput($sformatf("vert_rdy_%0d", idx), {15'b0, cmd_rdy}, 16'h1);
    if (cmd_rdy === 1'b1) legCount++;
    clr_cmd_rdy = 1'b1;
    #1;
    checkOutput($sformatf("uart_blocked_v_%0d", idx), {15'b0, clr_cmd_rdy_UART}, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput($sformatf("hold_v_rdy_%0d", idx), {15'b0, cmd_rdy}, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput($sformatf("horz_cmd_%0d", idx), cmd, expHorz(mv));
    checkOutput($sformatf("horz_rdy_%0d", idx), {15'b0, cmd_rdy}, 16'h1);
    if (cmd_rdy === 1'b1) legCount++;
    clr_cmd_rdy = 1'b1;
    #1;
    checkOutput($sformatf("uart_blocked_h_%0d", idx), {15'b0, clr_cmd_rdy_UART}, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput($sformatf("hold_h_rdy_%0d", idx), {15'b0, cmd_rdy}, 16'h0);
    checkOutput($sformatf("hold_h_resp_%0d", idx), {8'b0, resp},
                (idx[4:0] == lastIdx) ? 16'h00A5 : 16'h005A);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    move         = 8'h00;
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_mv_indx", {11'b0, mv_indx}, 16'h0);
    checkOutput("rst_cmd_rdy", {15'b0, cmd_rdy}, 16'h0);
    checkOutput("rst_clr_uart", {15'b0, clr_cmd_rdy_UART}, 16'h0);
    checkOutput("rst_cmd_mux", cmd, 16'h1234);
    checkOutput("rst_resp", {8'b0, resp}, 16'h00A5);
    #10;
    rst_n = 1'b1;

    // UART passthrough
    cmd_UART     = 16'h43F3;
    cmd_rdy_UART = 1'b1;
    #1;
    checkOutput("uart_cmd", cmd, 16'h43F3);
    checkOutput("uart_rdy", {15'b0, cmd_rdy}, 16'h1);
    clr_cmd_rdy = 1'b1;
    #1;
    checkOutput("uart_clr_pass", {15'b0, clr_cmd_rdy_UART}, 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("uart_clr_drop", {15'b0, clr_cmd_rdy_UART}, 16'h0);
    checkOutput("uart_resp", {8'b0, resp}, 16'h00A5);
    checkOutput("uart_still_idle", cmd, 16'h43F3);
    cmd_rdy_UART = 1'b0;

    // Single leg pair with stray events, start_tour wins over send_resp
    move = 8'h08;
    applyStimulus(1'b1, 1'b0, 1'b1);
    cmd_UART     = 16'h2000;
    cmd_rdy_UART = 1'b1;
    #1;
    checkOutput("leg_vert_cmd", cmd, 16'h47F1);
    checkOutput("leg_vert_rdy", {15'b0, cmd_rdy}, 16'h1);
    checkOutput("leg_mv_indx", {11'b0, mv_indx}, 16'h0);
    checkOutput("leg_vert_resp", {8'b0, resp}, 16'h005A);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("stray_resp_cmd", cmd, 16'h47F1);
    checkOutput("stray_resp_rdy", {15'b0, cmd_rdy}, 16'h1);
    legCount++;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hold_v_rdy", {15'b0, cmd_rdy}, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stray_start_rdy", {15'b0, cmd_rdy}, 16'h0);
    checkOutput("stray_start_idx", {11'b0, mv_indx}, 16'h0);
    checkOutput("stray_start_cmd", cmd, 16'h47F1);
    checkOutput("stray_start_clr", {15'b0, clr_cmd_rdy_UART}, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("leg_horz_cmd", cmd, 16'h53F2);
    checkOutput("leg_horz_rdy", {15'b0, cmd_rdy}, 16'h1);
    legCount++;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("leg_hold_h_resp", {8'b0, resp}, 16'h005A);
    checkOutput("leg_hold_h_rdy", {15'b0, cmd_rdy}, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Rest of the full tour with a UART command pending throughout
    for (int i = 1; i < 24; i++) runMove(i, 5'd23);
    checkOutput("tour_legs", legCount[15:0], 16'd48);
    checkOutput("end_cmd_uart", cmd, 16'h2000);
    checkOutput("end_rdy_uart", {15'b0, cmd_rdy}, 16'h1);
    checkOutput("end_resp", {8'b0, resp}, 16'h00A5);
    checkOutput("end_mv_indx_sat", {11'b0, mv_indx}, 16'd23);
    clr_cmd_rdy = 1'b1;
    #1;
    checkOutput("end_clr_uart", {15'b0, clr_cmd_rdy_UART}, 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cmd_rdy_UART = 1'b0;

    // Reset mid-tour while in HOLD_H of move 7
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      move = tourMove(i);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    move = 8'h80;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_idx", {11'b0, mv_indx}, 16'd7);
    checkOutput("pre_rst_cmd", cmd, 16'h5BF2);
    checkOutput("pre_rst_resp", {8'b0, resp}, 16'h005A);
    cmd_UART     = 16'h4BF1;
    cmd_rdy_UART = 1'b1;
    rst_n        = 1'b0;
    #1;
    checkOutput("mid_rst_idx", {11'b0, mv_indx}, 16'h0);
    checkOutput("mid_rst_rdy", {15'b0, cmd_rdy}, 16'h1);
    checkOutput("mid_rst_cmd", cmd, 16'h4BF1);
    checkOutput("mid_rst_resp", {8'b0, resp}, 16'h00A5);
    cmd_rdy_UART = 1'b0;
    #1;
    checkOutput("mid_rst_rdy_follow", {15'b0, cmd_rdy}, 16'h0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("post_rst_idle", cmd, 16'h4BF1);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
